alu_mul_seq: RTL and testbench



---
 rtl/alu_mul_seq_pkg.sv | 25 ++
 rtl/alu_port_mux.sv | 32 +++
 rtl/alu_mul_seq.sv | 152 +++++++++++++++
 tb/tb_alu_mul_seq.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mul_seq_pkg.sv
// alu_mul_seq shared constants: FSM states, ALU op codes, add carry helper.
// Optional feature macro: MUL_EARLY_TERM_EN (see alu_mul_seq.sv).
package alu_mul_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Carry out of an add, rebuilt from the operand and sum MSBs
  // because the shared ALU exposes no carry flag.
  function automatic logic add_carry(
    input logic a_msb,
    input logic b_msb,
    input logic z_msb
  );
    return (a_msb & b_msb) | ((a_msb | b_msb) & ~z_msb);
  endfunction

endpackage

// File: rtl/alu_port_mux.sv
// alu_port_mux: selects who drives the shared ALU ports.
// own_i=1 gives the ports to the multiply sequencer.
module alu_port_mux
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             own_i,
  input  logic [WIDTH-1:0] seq_a,
  input  logic [WIDTH-1:0] seq_b,
  input  logic [2:0]       seq_op,
  input  logic [WIDTH-1:0] dp_a,
  input  logic [WIDTH-1:0] dp_b,
  input  logic [2:0]       dp_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op
);

  // Pure combinational 2:1 select of the {a,b,op} bundle
  always_comb begin
    alu_a  = dp_a;
    alu_b  = dp_b;
    alu_op = dp_op;
    if (own_i) begin
      alu_a  = seq_a;
      alu_b  = seq_b;
      alu_op = seq_op;
    end
  end

endmodule

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add 32x32->64 multiplier borrowing the EX ALU.
// Define MUL_EARLY_TERM_EN to stop once the remaining multiplier bits are 0.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_mcand,
  input  logic [WIDTH-1:0] req_mplier,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  input  logic [WIDTH-1:0] dp_a,
  input  logic [WIDTH-1:0] dp_b,
  input  logic [2:0]       dp_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_z,
  output logic             dp_stall
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             own;
  logic             carry;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] fin_hi, fin_lo;
  logic             finish;

  assign own       = (state_q == ST_ITER);
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_hi    = hi_q;
  assign rsp_lo    = lo_q;
  assign dp_stall  = own;

  alu_port_mux #(
    .WIDTH (WIDTH)
  ) u_mux (
    .own_i  (own),
    .seq_a  (hi_q),
    .seq_b  (mcand_q),
    .seq_op (ALU_ADD),
    .dp_a   (dp_a),
    .dp_b   (dp_b),
    .dp_op  (dp_op),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_op (alu_op)
  );

  // One shift-add step: add mcand into hi when lo[0], then shift {hi,lo} right
  always_comb begin
    carry = add_carry(hi_q[WIDTH-1], mcand_q[WIDTH-1], alu_z[WIDTH-1]);
    if (lo_q[0]) begin
      step_hi = {carry, alu_z[WIDTH-1:1]};
      step_lo = {alu_z[0], lo_q[WIDTH-1:1]};
    end else begin
      step_hi = {1'b0, hi_q[WIDTH-1:1]};
      step_lo = {hi_q[0], lo_q[WIDTH-1:1]};
    end
  end

`ifdef MUL_EARLY_TERM_EN
  logic [WIDTH-1:0] rest_mask;
  logic [WIDTH-1:0] rest_bits;
  logic [CNT_W-1:0] fin_sh;

  // Once no set multiplier bit remains above the current one, the
  // remaining steps are pure shifts: fold them into one final shift.
  always_comb begin
    rest_mask = {WIDTH{1'b1}} >> cnt_q;
    rest_bits = lo_q & rest_mask & ~WIDTH'(1);
    fin_sh    = CNT_W'(WIDTH - 1) - cnt_q;
    finish    = (rest_bits == '0) ||
                (cnt_q == CNT_W'(WIDTH - 1));
    {fin_hi, fin_lo} = {step_hi, step_lo} >> fin_sh;
  end
`else
  // Fixed schedule: done after the last counted iteration
  always_comb begin
    finish = (cnt_q == CNT_W'(WIDTH - 1));
    fin_hi = step_hi;
    fin_lo = step_lo;
  end
`endif

  // FSM and datapath register next-state
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          mcand_d = req_mcand;
          lo_d    = req_mplier;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        hi_d  = fin_hi;
        lo_d  = fin_lo;
        cnt_d = finish ? '0 : cnt_q + 1'b1;
        if (finish) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and product registers, async reset aborts any multiply
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: randomized and directed checks of alu_mul_seq
// against a plain-arithmetic product and latency model.
module tb_alu_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_mcand;
  logic [31:0] req_mplier;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_hi;
  logic [31:0] rsp_lo;
  logic [31:0] dp_a;
  logic [31:0] dp_b;
  logic [2:0]  dp_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_z;
  logic        dp_stall;

  int checks;
  int errors;

  alu_mul_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mcand  (req_mcand),
    .req_mplier (req_mplier),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_hi     (rsp_hi),
    .rsp_lo     (rsp_lo),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_op      (dp_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_z      (alu_z),
    .dp_stall   (dp_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      3'b000:  alu_z = alu_a & alu_b;
      3'b001:  alu_z = alu_a | alu_b;
      3'b010:  alu_z = alu_a + alu_b;
      3'b110:  alu_z = alu_a - alu_b;
      3'b111:  alu_z = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_z = 32'd0;
    endcase
  end

  function automatic logic [63:0] ref_prod(input logic [31:0] a, b);
    logic [63:0] wa;
    logic [63:0] wb;
    wa = {32'd0, a};
    wb = {32'd0, b};
    return wa * wb;
  endfunction

  // Cycles from the accept cycle to the first cycle showing rsp_valid
  function automatic int ref_lat(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
    int msb;
    msb = 0;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
    return 2 + msb;
`else
    if (b == 32'hFFFF_FFFF) return 33;
    return 33;
`endif
  endfunction

  task automatic run_mul(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output int          lat,
    output int          stalls,
    output bit          to
  );
    @(negedge clk);
    req_mcand  = a;
    req_mplier = b;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat    = 1;
    stalls = 0;
    while (!rsp_valid && lat < 200) begin
      if (dp_stall) stalls++;
      @(negedge clk);
      lat++;
    end
    to = !rsp_valid;
    hi = rsp_hi;
    lo = rsp_lo;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || dp_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b valid=%b stall=%b need 1 0 0",
               req_ready, rsp_valid, dp_stall);
    end
    checks++;
    if (rsp_hi !== 32'd0 || rsp_lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_prod: got %h_%h need 0", rsp_hi, rsp_lo);
    end
  endtask

  task automatic test_basic;
    logic [31:0] hi, lo;
    int lat, stalls;
    bit to;
    logic [63:0] exp;
    exp = ref_prod(32'd7, 32'd6);
    run_mul(32'd7, 32'd6, hi, lo, lat, stalls, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL basic_timeout: no rsp_valid in 200 cycles");
    end
    checks++;
    if ({hi, lo} !== exp) begin
      errors++;
      $display("FAIL basic_prod: got %h_%h need %h", hi, lo, exp);
    end
    checks++;
    if (lat !== ref_lat(32'd6)) begin
      errors++;
      $display("FAIL basic_lat: got %0d need %0d", lat, ref_lat(32'd6));
    end
    checks++;
    if (stalls !== ref_lat(32'd6) - 1) begin
      errors++;
      $display("FAIL basic_stall: got %0d need %0d",
               stalls, ref_lat(32'd6) - 1);
    end
  endtask

  task automatic test_carry;
    logic [31:0] hi, lo;
    int lat, stalls;
    bit to;
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, hi, lo, lat, stalls, to);
    checks++;
    if (to || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      errors++;
      $display("FAIL carry_prod: got %h_%h to=%0d need fffffffe_00000001",
               hi, lo, to);
    end
    checks++;
    if (lat !== ref_lat(32'hFFFF_FFFF)) begin
      errors++;
      $display("FAIL carry_lat: got %0d need %0d",
               lat, ref_lat(32'hFFFF_FFFF));
    end
  endtask

  task automatic test_zero;
    logic [31:0] hi, lo;
    int lat, stalls;
    bit to;
    run_mul(32'd0, 32'hDEAD_BEEF, hi, lo, lat, stalls, to);
    checks++;
    if (to || {hi, lo} !== 64'd0) begin
      errors++;
      $display("FAIL zero_mcand: got %h_%h need 0", hi, lo);
    end
    run_mul(32'hCAFE_F00D, 32'd0, hi, lo, lat, stalls, to);
    checks++;
    if (to || {hi, lo} !== 64'd0 || lat !== ref_lat(32'd0)) begin
      errors++;
      $display("FAIL zero_mplier: got %h_%h lat %0d need 0 lat %0d",
               hi, lo, lat, ref_lat(32'd0));
    end
  endtask

  task automatic test_passthru;
    int n;
    @(negedge clk);
    dp_a  = 32'd5;
    dp_b  = 32'd3;
    dp_op = 3'b110;
    #1;
    checks++;
    if (alu_z !== 32'd2 || alu_op !== 3'b110 || dp_stall !== 1'b0) begin
      errors++;
      $display("FAIL pass_idle: z=%0d op=%b stall=%b need 2 110 0",
               alu_z, alu_op, dp_stall);
    end
    req_mcand  = 32'h0000_0100;
    req_mplier = 32'h8000_0001;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (alu_op !== 3'b010 || dp_stall !== 1'b1 ||
        alu_b !== 32'h0000_0100) begin
      errors++;
      $display("FAIL pass_iter: op=%b stall=%b b=%h need 010 1 00000100",
               alu_op, dp_stall, alu_b);
    end
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || alu_z !== 32'd2 || dp_stall !== 1'b0 ||
        {rsp_hi, rsp_lo} !== ref_prod(32'h100, 32'h8000_0001)) begin
      errors++;
      $display("FAIL pass_done: v=%b z=%0d stall=%b prod=%h_%h",
               rsp_valid, alu_z, dp_stall, rsp_hi, rsp_lo);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_hold;
    logic [63:0] exp1, exp2;
    int n;
    bit bad;
    exp1 = ref_prod(32'd123456, 32'd654321);
    exp2 = ref_prod(32'h1357_9BDF, 32'h0246_8ACE);
    @(negedge clk);
    req_mcand  = 32'd123456;
    req_mplier = 32'd654321;
    req_valid  = 1'b1;
    @(negedge clk);
    req_mcand  = 32'h1357_9BDF;
    req_mplier = 32'h0246_8ACE;
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    bad = !rsp_valid;
    for (int i = 0; i < 5; i++) begin
      if ({rsp_hi, rsp_lo} !== exp1 || req_ready !== 1'b0 ||
          rsp_valid !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold_stable: got %h_%h ready=%b need %h ready=0",
               rsp_hi, rsp_lo, req_ready, exp1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || dp_stall !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: v=%b ready=%b stall=%b need 0 1 0",
               rsp_valid, req_ready, dp_stall);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (dp_stall !== 1'b1) begin
      errors++;
      $display("FAIL hold_accept: stall=%b need 1", dp_stall);
    end
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || {rsp_hi, rsp_lo} !== exp2) begin
      errors++;
      $display("FAIL hold_second: got %h_%h need %h",
               rsp_hi, rsp_lo, exp2);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit seen;
    @(negedge clk);
    req_mcand  = 32'hFFFF_0000;
    req_mplier = 32'hFFFF_FFFF;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    dp_a  = 32'hA5A5_0001;
    dp_b  = 32'h0000_0F0F;
    dp_op = 3'b001;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || dp_stall !== 1'b0 ||
        alu_a !== dp_a || alu_b !== dp_b || alu_op !== dp_op) begin
      errors++;
      $display("FAIL midreset: ready=%b v=%b stall=%b a=%h op=%b",
               req_ready, rsp_valid, dp_stall, alu_a, alu_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid || dp_stall) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midreset_abort: got response/stall after reset need none");
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, hi, lo;
    int lat, stalls;
    bit to;
    logic [63:0] exp;
    for (int k = 0; k < 24; k++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (k == 3) a = 32'h8000_0000;
      if (k == 4) b = 32'h8000_0000;
      exp = ref_prod(a, b);
      run_mul(a, b, hi, lo, lat, stalls, to);
      checks++;
      if (to || {hi, lo} !== exp) begin
        errors++;
        $display("FAIL rand_prod[%0d]: %h*%h got %h_%h need %h",
                 k, a, b, hi, lo, exp);
      end
      checks++;
      if (lat !== ref_lat(b) || stalls !== ref_lat(b) - 1) begin
        errors++;
        $display("FAIL rand_lat[%0d]: got %0d/%0d need %0d/%0d",
                 k, lat, stalls, ref_lat(b), ref_lat(b) - 1);
      end
    end
  endtask

`ifdef MUL_EARLY_TERM_EN
  task automatic test_early;
    logic [31:0] hi, lo;
    int lat, stalls;
    bit to;
    run_mul(32'h1234_5678, 32'd1, hi, lo, lat, stalls, to);
    checks++;
    if (to || hi !== 32'd0 || lo !== 32'h1234_5678 || lat !== 2) begin
      errors++;
      $display("FAIL early_one: got %h_%h lat %0d need 0_12345678 lat 2",
               hi, lo, lat);
    end
  endtask
`endif

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_mcand  = 32'd0;
    req_mplier = 32'd0;
    rsp_ready  = 1'b0;
    dp_a       = 32'd0;
    dp_b       = 32'd0;
    dp_op      = 3'b000;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_basic;
    test_carry;
    test_zero;
    test_passthru;
    test_hold;
    test_reset_mid;
`ifdef MUL_EARLY_TERM_EN
    test_early;
`endif
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
